mem_byte_ctrl: RTL

Byte-serialising memory controller between the datapath's MOV/MOC memory handshake and a 512×8 synchronous single-port byte memory. It accepts one 32-bit load or store request per handshake, decodes access size and signedness from the MIPS opcode, and moves 1, 2 or 4 bytes in big-endian order. Load results are sign- or zero-extended before they are returned. It sits directly downstream of the datapath's MAR/DataIn/RW/MOV outputs and directly upstream of the byte RAM.

---
 rtl/mem_byte_ctrl_if.sv | 32 +++
 rtl/mem_byte_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_ctrl_if.sv
// rtl/mem_byte_ctrl_if.sv - datapath-side memory handshake bundle for mem_byte_ctrl
//
// Groups the MOV/MOC request handshake between the datapath and the byte
// controller.
//   master (datapath)   : drives MOV, RW, OpC, MAR, DataIn; sees DataOut, MOC,
//                         align_err, busy
//   slave  (controller) : the mirror image
// ADDR_W is the byte-address width and must match the controller.

interface mem_byte_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              MOV;
  logic              RW;
  logic [5:0]        OpC;
  logic [ADDR_W-1:0] MAR;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              MOC;
  logic              align_err;
  logic              busy;

  modport master (
    output MOV, RW, OpC, MAR, DataIn,
    input  DataOut, MOC, align_err, busy
  );

  modport slave (
    input  MOV, RW, OpC, MAR, DataIn,
    output DataOut, MOC, align_err, busy
  );
endinterface

// File: rtl/mem_byte_ctrl.sv
// rtl/mem_byte_ctrl.sv - byte-serialising load/store controller for a 2^ADDR_W x 8 sync RAM
//
// Accepts one load/store per MOV/MOC handshake, decodes size (OpC[1:0]) and
// zero/sign extension (OpC[2]), and moves 1, 2 or 4 bytes big-endian to or
// from a synchronous single-port byte RAM. Address arithmetic wraps modulo
// 2^ADDR_W.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   dp         slave modport of mem_byte_ctrl_if (MOV, RW, OpC, MAR, DataIn,
//              DataOut, MOC, align_err, busy)
//   mem_addr   out  byte address to RAM
//   mem_wdata  out  write byte to RAM
//   mem_we     out  RAM write enable
//   mem_rdata  in   RAM read byte, valid the cycle after mem_addr
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word requests skip the RAM and finish in one
//               edge with align_err = 1
//   undefined : align_err stays 0 and unaligned addresses are used as-is

module mem_byte_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  mem_byte_ctrl_if.slave    dp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RTAIL = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nx;

  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              rw_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;     // n-1: index of the final byte
  logic [23:0]       asm_q;      // earlier read bytes, newest in [7:0]
  logic [31:0]       data_out_q;
  logic              align_err_q;

  logic [1:0]        req_last;
  logic              misaligned;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [31:0]       rd_ext;

  always_comb begin
    req_last = 2'd3;
    case (dp.OpC[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((dp.OpC[1:0] == 2'b01) && dp.MAR[0]) ||
                      (dp.OpC[1] && (dp.MAR[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Final assembled load word: bytes captured so far plus the one on the bus.
  assign rd_word = {asm_q, mem_rdata};

  always_comb begin
    rd_ext = rd_word;
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'h0, rd_word[7:0]}
                              : {{24{rd_word[7]}}, rd_word[7:0]};
      2'b01:   rd_ext = uns_q ? {16'h0, rd_word[15:0]}
                              : {{16{rd_word[15]}}, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dp.MOV) state_nx = misaligned ? DONE : XFER;
      end
      XFER: begin
        if (cnt_q == last_q) state_nx = rw_q ? RTAIL : DONE;
      end
      RTAIL: state_nx = DONE;
      DONE: begin
        // MOV must be seen low before another request is accepted.
        if (!dp.MOV) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      asm_q       <= '0;
      data_out_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dp.MOV) begin
            base_q      <= dp.MAR;
            wdata_q     <= dp.DataIn;
            rw_q        <= dp.RW;
            uns_q       <= dp.OpC[2];
            size_q      <= dp.OpC[1:0];
            last_q      <= req_last;
            cnt_q       <= 2'd0;
            asm_q       <= '0;
            align_err_q <= misaligned;
          end
        end
        XFER: begin
          cnt_q <= cnt_q + 2'd1;
          // RAM returns the byte for the previous cycle's address.
          if (rw_q && (cnt_q != 2'd0)) asm_q <= {asm_q[15:0], mem_rdata};
        end
        RTAIL: begin
          data_out_q <= rd_ext;
        end
        DONE: begin
          if (!dp.MOV) align_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Write lane: byte cnt counted from the MSB of the access.
  assign lane = last_q - cnt_q;

  // Output logic
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    if (state == XFER) begin
      mem_addr = base_q + ADDR_W'(cnt_q);
      if (!rw_q) begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q[{lane, 3'b000} +: 8];
      end
    end
  end

  assign dp.MOC       = (state == DONE);
  assign dp.busy      = (state != IDLE);
  assign dp.DataOut   = data_out_q;
  assign dp.align_err = align_err_q;

endmodule
